// File: rtl/debounce_pkg.sv
// ============================================================================
// Module      : debounce_pkg
// Description : Shared types and helpers for the input_debouncer block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package debounce_pkg;

    // Width of a counter that must hold values 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } debounce_edge_t;

endpackage : debounce_pkg

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// Module      : debounce_channel
// Description : Single-bit debounce: stability counter, level register,
//               registered rise/fall pulses. Optional auto-repeat of the
//               rise pulse when DEBOUNCE_AUTOREPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic        RESET_VALUE   = 1'b0,
    parameter int unsigned REPEAT_CYCLES = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sample_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535) begin : g_bad_stable
        $error("debounce_channel: STABLE_CYCLES out of range 2..65535");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("debounce_channel: REPEAT_CYCLES must be at least 2");
    end

    localparam int             CW     = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]  C_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]  C_ONE  = CW'(1);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic           level_q, level_d;
    logic           rise_q, rise_d;
    logic           fall_q, fall_d;
    debounce_edge_t w_edge;
    logic           w_rpt_fire;

    // Any cycle matching the accepted level discards the partial count.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        w_edge  = EDGE_NONE;
        if (sample_i == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == C_LAST) begin
            cnt_d   = '0;
            level_d = sample_i;
            w_edge  = sample_i ? EDGE_RISE : EDGE_FALL;
        end else begin
            cnt_d = cnt_q + C_ONE;
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int            RW     = cnt_width(REPEAT_CYCLES);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);
    localparam logic [RW-1:0] R_ONE  = RW'(1);

    logic [RW-1:0] rpt_q, rpt_d;

    always_comb begin
        rpt_d      = rpt_q;
        w_rpt_fire = 1'b0;
        if (w_edge != EDGE_NONE || !level_q) begin
            rpt_d = '0;
        end else if (rpt_q == R_LAST) begin
            rpt_d      = '0;
            w_rpt_fire = 1'b1;
        end else begin
            rpt_d = rpt_q + R_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    assign w_rpt_fire = 1'b0;
`endif

    assign rise_d = (w_edge == EDGE_RISE) | w_rpt_fire;
    assign fall_d = (w_edge == EDGE_FALL);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            level_q <= RESET_VALUE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule : debounce_channel

`default_nettype wire

// File: rtl/input_debouncer.sv
// ============================================================================
// Module      : input_debouncer
// Description : WIDTH independent debounce channels with one-cycle rise/fall
//               event pulses. Define DEBOUNCE_AUTOREPEAT_EN for auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned       WIDTH         = 1,
    parameter int unsigned       STABLE_CYCLES = 4,
    parameter logic [WIDTH-1:0]  RESET_VALUE   = '0,
    parameter int unsigned       REPEAT_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample_in,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_VALUE   (RESET_VALUE[g]),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_chan (
            .clk_i    (clk),
            .rst_i    (reset),
            .sample_i (sample_in[g]),
            .level_o  (debounced[g]),
            .rise_o   (rise_pulse[g]),
            .fall_o   (fall_pulse[g])
        );
    end

endmodule : input_debouncer

`default_nettype wire

// File: tb/tb_input_debouncer.sv
// ============================================================================
// Module      : tb_input_debouncer
// Description : Self-checking bench for input_debouncer (WIDTH=2, STABLE=4).
//               Auto-repeat scenario runs when DEBOUNCE_AUTOREPEAT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_debouncer;

    localparam int         W  = 2;
    localparam int         S  = 4;
    localparam int         R  = 8;
    localparam logic [1:0] RV = 2'b00;

    logic         clk;
    logic         reset;
    logic [W-1:0] sample_in;
    logic [W-1:0] debounced;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;

    int n_chk  = 0;
    int n_fail = 0;

    input_debouncer #(
        .WIDTH         (W),
        .STABLE_CYCLES (S),
        .RESET_VALUE   (RV),
        .REPEAT_CYCLES (R)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_in  (sample_in),
        .debounced  (debounced),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once the last S sampled values
    // all differ from the current accepted level.
    logic         hist [W][S];
    int           nsamp [W];
    int           age [W];
    logic [W-1:0] m_deb, m_rise, m_fall;
    bit           all_diff;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < W; c++) begin
                nsamp[c] = 0;
                age[c]   = 0;
            end
            m_deb  = RV;
            m_rise = '0;
            m_fall = '0;
        end else begin
            for (int c = 0; c < W; c++) begin
                for (int k = 0; k < S - 1; k++) hist[c][k] = hist[c][k+1];
                hist[c][S-1] = sample_in[c];
                if (nsamp[c] < S) nsamp[c]++;
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                all_diff  = (nsamp[c] == S);
                for (int k = 0; k < S; k++)
                    if (hist[c][k] == m_deb[c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_deb[c]  = ~m_deb[c];
                    m_rise[c] = m_deb[c];
                    m_fall[c] = ~m_deb[c];
                    age[c]    = 0;
                end
`ifdef DEBOUNCE_AUTOREPEAT_EN
                else if (m_deb[c]) begin
                    age[c]++;
                    if (age[c] % R == 0) m_rise[c] = 1'b1;
                end
`endif
            end
        end
    end

    logic [W-1:0] pulse_acc;

    always @(negedge clk) begin
        chk("cyc_debounced", debounced, m_deb);
        chk("cyc_rise", rise_pulse, m_rise);
        chk("cyc_fall", fall_pulse, m_fall);
        pulse_acc = pulse_acc | rise_pulse | fall_pulse;
    end

    logic [1:0] ind_tbl [9] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b11,
                                2'b11, 2'b11, 2'b11, 2'b11};
    logic       glitch_tbl [8] = '{1, 1, 1, 0, 1, 1, 1, 0};

    initial begin
        reset     = 1'b1;
        sample_in = '0;
        pulse_acc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_deb", debounced, 2'b00);
        chk("reset_rise", rise_pulse, 2'b00);
        chk("reset_fall", fall_pulse, 2'b00);
        #1 reset = 1'b0;

        // Clean press on bit0
        @(posedge clk); #2 sample_in = 2'b01;
        repeat (3) @(posedge clk);
        #1 chk("press_wait", debounced, 2'b00);
        @(posedge clk);
        #1;
        chk("press_deb", debounced, 2'b01);
        chk("press_rise", rise_pulse, 2'b01);
        chk("press_nofall", fall_pulse, 2'b00);
        @(posedge clk);
        #1 chk("press_oneshot", rise_pulse, 2'b00);

        // Release
        #1 sample_in = 2'b00;
        repeat (3) @(posedge clk);
        #1 chk("rel_wait", debounced, 2'b01);
        @(posedge clk);
        #1;
        chk("rel_deb", debounced, 2'b00);
        chk("rel_fall", fall_pulse, 2'b01);
        @(posedge clk);
        #1 chk("rel_oneshot", fall_pulse, 2'b00);

        // Glitch rejection
        pulse_acc = '0;
        for (int i = 0; i < 8; i++) begin
            #1 sample_in = {1'b0, glitch_tbl[i]};
            @(posedge clk);
            #1;
        end
        repeat (5) @(posedge clk);
        #1;
        chk("glitch_deb", debounced, 2'b00);
        chk("glitch_pulses", pulse_acc, 2'b00);

        // Reset mid-count from an accepted high level
        #1 sample_in = 2'b01;
        repeat (5) @(posedge clk);
        #1 chk("pre_reset_deb", debounced, 2'b01);
        #1 sample_in = 2'b00;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_deb", debounced, 2'b00);
        chk("async_rst_fall", fall_pulse, 2'b00);
        sample_in = 2'b01;
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("fresh_wait_deb", debounced, 2'b00);
        chk("fresh_wait_rise", rise_pulse, 2'b00);
        @(posedge clk);
        #1 chk("fresh_rise", rise_pulse, 2'b01);

        // Independent channels, bit1 glitches once
        #1 sample_in = 2'b00;
        repeat (6) @(posedge clk);
        #2 sample_in = ind_tbl[0];
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            if (e == 4) chk("ind_bit0_rise", rise_pulse, 2'b01);
            if (e == 7) begin
                chk("ind_bit1_rise", rise_pulse, 2'b10);
                chk("ind_deb", debounced, 2'b11);
            end
            #1 sample_in = ind_tbl[e];
        end

`ifdef DEBOUNCE_AUTOREPEAT_EN
        sample_in = 2'b00;
        repeat (6) @(posedge clk);
        #2 sample_in = 2'b01;
        repeat (4) @(posedge clk);
        for (int k = 0; k <= 40; k++) begin
            #1;
            chk("rpt_rise", 32'(rise_pulse[0]), 32'((k <= 24) && (k % R == 0)));
            chk("rpt_fall", 32'(fall_pulse[0]), 32'(k == 30));
            if (k == 26) sample_in = 2'b00;
            @(posedge clk);
        end
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_input_debouncer

`default_nettype wire
